// File: rtl/mult2.sv
// rtl/mult2.sv - second multiplier stage: partial-product sum, signed fix-up, HI/LO update
//
// Ports:
//   Clock            rising-edge clock
//   Reset            asynchronous active-high reset
//   InValid          an operation is presented this cycle
//   Op[2:0]          000 MULTU, 001 MULT, 010 MADDU, 011 MADD,
//                    100 MSUBU, 101 MSUB, 110 MTHI, 111 MTLO
//   A[31:0], B[31:0] operands (A also carries MTHI/MTLO data)
//   SubOut0..15      8x8 partial products from mult1, SubOut[4i+j] = A.byte i * B.byte j
//                    (byte 0 is bits [31:24], byte 3 is bits [7:0])
//   Stall            freezes every register
//   HI, LO           architectural HI/LO registers
//   OutValid         HI/LO were updated by the most recent enabled edge
module mult2 (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InValid,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [15:0] SubOut0,
    input  logic [15:0] SubOut1,
    input  logic [15:0] SubOut2,
    input  logic [15:0] SubOut3,
    input  logic [15:0] SubOut4,
    input  logic [15:0] SubOut5,
    input  logic [15:0] SubOut6,
    input  logic [15:0] SubOut7,
    input  logic [15:0] SubOut8,
    input  logic [15:0] SubOut9,
    input  logic [15:0] SubOut10,
    input  logic [15:0] SubOut11,
    input  logic [15:0] SubOut12,
    input  logic [15:0] SubOut13,
    input  logic [15:0] SubOut14,
    input  logic [15:0] SubOut15,
    input  logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        OutValid
);

    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_MADDU = 3'b010,
        OP_MADD  = 3'b011,
        OP_MSUBU = 3'b100,
        OP_MSUB  = 3'b101,
        OP_MTHI  = 3'b110,
        OP_MTLO  = 3'b111
    } op_t;

    logic [15:0] sub_out [16];

    assign sub_out[0]  = SubOut0;
    assign sub_out[1]  = SubOut1;
    assign sub_out[2]  = SubOut2;
    assign sub_out[3]  = SubOut3;
    assign sub_out[4]  = SubOut4;
    assign sub_out[5]  = SubOut5;
    assign sub_out[6]  = SubOut6;
    assign sub_out[7]  = SubOut7;
    assign sub_out[8]  = SubOut8;
    assign sub_out[9]  = SubOut9;
    assign sub_out[10] = SubOut10;
    assign sub_out[11] = SubOut11;
    assign sub_out[12] = SubOut12;
    assign sub_out[13] = SubOut13;
    assign sub_out[14] = SubOut14;
    assign sub_out[15] = SubOut15;

    logic [63:0] unsigned_sum;
    logic [63:0] product;
    logic        is_signed;

    // Byte i sits at weight 8*(3-i), so product i,j sits at 8*(6-i-j).
    always_comb begin
        unsigned_sum = 64'd0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                unsigned_sum = unsigned_sum
                    + ({48'd0, sub_out[4*i+j]} << (8 * (6 - i - j)));
            end
        end
    end

    // Odd opcodes among the multiply group are the signed variants.
    assign is_signed = Op[0] && (Op != OP_MTLO);

    // Two's-complement fix-up: treating a negative operand as unsigned adds
    // 2^32 times the other operand, which is removed here (mod 2^64).
    always_comb begin
        product = unsigned_sum;
        if (is_signed) begin
            if (A[31]) product = product - {B, 32'd0};
            if (B[31]) product = product - {A, 32'd0};
        end
    end

    logic        s1_valid;
    op_t         s1_op;
    logic [31:0] s1_a;
    logic [63:0] s1_p;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_MULTU;
            s1_a     <= 32'd0;
            s1_p     <= 64'd0;
        end else if (!Stall) begin
            s1_valid <= InValid;
            s1_op    <= op_t'(Op);
            s1_a     <= A;
            s1_p     <= product;
        end
    end

    // Stage 2 reads HI/LO as they are at this edge, so back-to-back
    // accumulates chain naturally without forwarding.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            HI       <= 32'd0;
            LO       <= 32'd0;
            OutValid <= 1'b0;
        end else if (!Stall) begin
            OutValid <= s1_valid;
            if (s1_valid) begin
                unique case (s1_op)
                    OP_MULTU, OP_MULT: {HI, LO} <= s1_p;
                    OP_MADDU, OP_MADD: {HI, LO} <= {HI, LO} + s1_p;
                    OP_MSUBU, OP_MSUB: {HI, LO} <= {HI, LO} - s1_p;
                    OP_MTHI:           HI <= s1_a;
                    OP_MTLO:           LO <= s1_a;
                    default:           ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult2.sv
// tb/tb_mult2.sv - self-checking bench for mult2
module tb_mult2;

    localparam logic [2:0] MULTU = 3'b000, MULT = 3'b001, MADDU = 3'b010, MADD = 3'b011,
                           MSUBU = 3'b100, MSUB = 3'b101, MTHI = 3'b110, MTLO = 3'b111;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        InValid;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Stall;
    logic [15:0] sub [16];
    logic [31:0] HI;
    logic [31:0] LO;
    logic        OutValid;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 Clock = ~Clock;

    mult2 dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .Op(Op), .A(A), .B(B),
        .SubOut0(sub[0]),   .SubOut1(sub[1]),   .SubOut2(sub[2]),   .SubOut3(sub[3]),
        .SubOut4(sub[4]),   .SubOut5(sub[5]),   .SubOut6(sub[6]),   .SubOut7(sub[7]),
        .SubOut8(sub[8]),   .SubOut9(sub[9]),   .SubOut10(sub[10]), .SubOut11(sub[11]),
        .SubOut12(sub[12]), .SubOut13(sub[13]), .SubOut14(sub[14]), .SubOut15(sub[15]),
        .Stall(Stall), .HI(HI), .LO(LO), .OutValid(OutValid)
    );

    // mult1 golden model: byte 0 is the most significant byte.
    task automatic drive(input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        InValid = v;
        Op      = op;
        A       = a;
        B       = b;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                sub[4*i+j] = {8'd0, a[8*(3-i) +: 8]} * {8'd0, b[8*(3-j) +: 8]};
            end
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[1]  = '{MULT,  32'h80000000, 32'h00000002, 64'hFFFFFFFF_00000000};
        vecs[2]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
        vecs[3]  = '{MADDU, 32'h00000002, 32'h00000003, 64'h00000000_00000007};
        vecs[4]  = '{MSUB,  32'h00000001, 32'h00000001, 64'h00000000_00000006};
        vecs[5]  = '{MSUB,  32'h00000001, 32'h00000007, 64'hFFFFFFFF_FFFFFFFF};
        vecs[6]  = '{MADDU, 32'h00000001, 32'h00000001, 64'h00000000_00000000};
        vecs[7]  = '{MTHI,  32'h12345678, 32'h0000FFFF, 64'h12345678_00000000};
        vecs[8]  = '{MTLO,  32'h9ABCDEF0, 32'hFFFF0000, 64'h12345678_9ABCDEF0};
        vecs[9]  = '{MADD,  32'hFFFFFFFF, 32'h00000002, 64'h12345678_9ABCDEEE};
        vecs[10] = '{MSUBU, 32'h00010000, 32'h00010000, 64'h12345677_9ABCDEEE};
        vecs[11] = '{MULT,  32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
        vecs[12] = '{MULTU, 32'h12345678, 32'h00000010, 64'h00000001_23456780};

        Reset = 1'b1;
        Stall = 1'b0;
        drive(1'b0, MULTU, 32'd0, 32'd0);
        tick();
        check("reset_hi", {32'd0, HI}, 64'd0);
        check("reset_lo", {32'd0, LO}, 64'd0);
        check("reset_ov", {63'd0, OutValid}, 64'd0);
        Reset = 1'b0;
        tick();

        for (int k = 0; k < 13; k++) begin
            drive(1'b1, vecs[k].op, vecs[k].a, vecs[k].b);
            tick();
            drive(1'b0, MULTU, 32'd0, 32'd0);
            check($sformatf("vec%0d_ov_before", k), {63'd0, OutValid}, 64'd0);
            tick();
            check($sformatf("vec%0d_hilo", k), {HI, LO}, vecs[k].exp);
            check($sformatf("vec%0d_ov", k), {63'd0, OutValid}, 64'd1);
            tick();
            check($sformatf("vec%0d_ov_after", k), {63'd0, OutValid}, 64'd0);
        end

        // Back-to-back: MTLO 1, MADDU 2x3, MSUB 1x7 with no bubbles.
        #2 Reset = 1'b1;
        #1 Reset = 1'b0;
        check("b2b_reset", {HI, LO}, 64'd0);
        drive(1'b1, MTLO, 32'd1, 32'd0);
        tick();
        drive(1'b1, MADDU, 32'd2, 32'd3);
        tick();
        check("b2b_mtlo", {HI, LO}, 64'd1);
        check("b2b_ov1", {63'd0, OutValid}, 64'd1);
        drive(1'b1, MSUB, 32'd1, 32'd7);
        tick();
        check("b2b_maddu", {HI, LO}, 64'd7);
        check("b2b_ov2", {63'd0, OutValid}, 64'd1);
        drive(1'b0, MULTU, 32'd0, 32'd0);
        tick();
        check("b2b_msub", {HI, LO}, 64'd0);
        check("b2b_ov3", {63'd0, OutValid}, 64'd1);
        tick();
        check("b2b_ov_end", {63'd0, OutValid}, 64'd0);

        // Wrap: MSUB 1x1 from zero, then MADDU 1x1 back to zero.
        drive(1'b1, MSUB, 32'd1, 32'd1);
        tick();
        drive(1'b1, MADDU, 32'd1, 32'd1);
        tick();
        check("wrap_neg", {HI, LO}, 64'hFFFFFFFF_FFFFFFFF);
        drive(1'b0, MULTU, 32'd0, 32'd0);
        tick();
        check("wrap_zero", {HI, LO}, 64'd0);
        check("wrap_ov", {63'd0, OutValid}, 64'd1);

        // Stall holds everything for four edges after accepting MULTU 3x5.
        drive(1'b1, MULTU, 32'd3, 32'd5);
        tick();
        Stall = 1'b1;
        drive(1'b1, MULTU, 32'd3, 32'd5);
        for (int s = 0; s < 4; s++) begin
            tick();
            check($sformatf("stall%0d_hilo", s), {HI, LO}, 64'd0);
            check($sformatf("stall%0d_ov", s), {63'd0, OutValid}, 64'd0);
        end
        Stall = 1'b0;
        drive(1'b0, MULTU, 32'd0, 32'd0);
        tick();
        check("stall_release", {HI, LO}, 64'd15);
        check("stall_release_ov", {63'd0, OutValid}, 64'd1);
        tick();

        // Reset between acceptance and the stage-2 edge discards the op.
        drive(1'b1, MULTU, 32'd7, 32'd9);
        tick();
        drive(1'b0, MULTU, 32'd0, 32'd0);
        #2 Reset = 1'b1;
        #1;
        check("rst_mid_hilo", {HI, LO}, 64'd0);
        check("rst_mid_ov", {63'd0, OutValid}, 64'd0);
        tick();
        Reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            tick();
            check($sformatf("rst_after%0d_hilo", r), {HI, LO}, 64'd0);
            check($sformatf("rst_after%0d_ov", r), {63'd0, OutValid}, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
